// File: rtl/lcd_cmd_fifo.sv
// Command/data queue feeding LCDCONTROL: circular buffer preloaded with the LCD init
// sequence at reset, producer backpressure, and optional hardware line-wrap insertion.
module lcd_cmd_fifo #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned NUM_INIT  = 5,
  parameter logic [71:0] INIT_SEQ  = {27'h0, 9'h080, 9'h006, 9'h001, 9'h00c, 9'h038},
  parameter int unsigned COLS      = 16,
  parameter bit          AUTO_WRAP = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic                     wr_rs,
  input  logic [7:0]               wr_data,
  output logic                     wr_wait,
  input  logic                     lcd_status,
  output logic                     lcd_write,
  output logic [8:0]               lcd_wrdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned ColW  = $clog2(COLS + 1);
  localparam int unsigned InitW = 9 * DEPTH;
  localparam logic [InitW-1:0] InitPad = InitW'(INIT_SEQ);

  logic [8:0]      mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            lcd_write_q, lcd_write_d;
  logic [8:0]      lcd_wrdata_q, lcd_wrdata_d;
  logic            overflow_q, overflow_d;
  logic [ColW-1:0] col_q, col_d;
  logic            line_q, line_d;
  logic            wrap_pend_q, wrap_pend_d;

  logic       busy, pop, full, space;
  logic       wrap_ins, accept, drop, push;
  logic [8:0] push_data;

  always_comb begin
    busy      = lcd_status | lcd_write_q;
    pop       = (count_q != '0) && !busy;
    full      = (count_q == CntW'(DEPTH));
    // A same-cycle pop frees a slot, so a push against a full queue still lands.
    space     = !full || pop;
    wrap_ins  = wrap_pend_q && space;
    accept    = wr_en && !wrap_pend_q && space;
    drop      = wr_en && !accept;
    push      = wrap_ins || accept;
    push_data = wrap_ins ? (line_q ? 9'h080 : 9'h0c0) : {wr_rs, wr_data};

    rd_ptr_d     = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    wr_ptr_d     = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    count_d      = count_q + CntW'(push) - CntW'(pop);
    lcd_write_d  = pop;
    lcd_wrdata_d = pop ? mem_q[rd_ptr_q] : lcd_wrdata_q;

    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Cursor follows only what actually enters the queue.
  always_comb begin
    col_d       = col_q;
    line_d      = line_q;
    wrap_pend_d = wrap_pend_q;
    if (AUTO_WRAP) begin
      if (wrap_ins) begin
        col_d       = '0;
        line_d      = ~line_q;
        wrap_pend_d = 1'b0;
      end else if (accept) begin
        if (wr_rs) begin
          col_d = col_q + ColW'(1);
          if (col_q == ColW'(COLS - 1)) begin
            wrap_pend_d = 1'b1;
          end
        end else if (wr_data == 8'h01 || wr_data == 8'h02) begin
          col_d  = '0;
          line_d = 1'b0;
        end else if (wr_data[7]) begin
          line_d = wr_data[6];
          if (32'(wr_data[5:0]) >= COLS) begin
            col_d = ColW'(COLS - 1);
          end else begin
            col_d = ColW'(wr_data[5:0]);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= (i < int'(NUM_INIT)) ? InitPad[9*i +: 9] : 9'h000;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= PtrW'(NUM_INIT);
      count_q      <= CntW'(NUM_INIT);
      lcd_write_q  <= 1'b0;
      lcd_wrdata_q <= '0;
      overflow_q   <= 1'b0;
      col_q        <= '0;
      line_q       <= 1'b0;
      wrap_pend_q  <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      lcd_write_q  <= lcd_write_d;
      lcd_wrdata_q <= lcd_wrdata_d;
      overflow_q   <= overflow_d;
      col_q        <= col_d;
      line_q       <= line_d;
      wrap_pend_q  <= wrap_pend_d;
    end
  end

  assign wr_wait    = full | wrap_pend_q;
  assign lcd_write  = lcd_write_q;
  assign lcd_wrdata = lcd_wrdata_q;
  assign count      = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_lcd_cmd_fifo.sv
// Bench for lcd_cmd_fifo: a wrapping and a non-wrapping instance driven in lockstep and
// compared every cycle against a queue-based reference of the queue and cursor rules.
module tb_lcd_cmd_fifo;

  localparam int unsigned DEPTH    = 32;
  localparam int unsigned NUM_INIT = 5;
  localparam int          COLS     = 16;
  localparam int unsigned CW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0, wr_rs = 1'b0, lcd_status = 1'b0, clr_ovf = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          ww0, ww1, lw0, lw1, ovf0, ovf1;
  logic [8:0]    ld0, ld1;
  logic [CW-1:0] cnt0, cnt1;

  int vectors = 0;
  int miscompares = 0;

  lcd_cmd_fifo #(.AUTO_WRAP(1'b1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_rs(wr_rs), .wr_data(wr_data),
    .wr_wait(ww0), .lcd_status(lcd_status), .lcd_write(lw0), .lcd_wrdata(ld0),
    .count(cnt0), .overflow(ovf0), .clr_ovf(clr_ovf)
  );

  lcd_cmd_fifo #(.AUTO_WRAP(1'b0)) u_nowrap (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_rs(wr_rs), .wr_data(wr_data),
    .wr_wait(ww1), .lcd_status(lcd_status), .lcd_write(lw1), .lcd_wrdata(ld1),
    .count(cnt1), .overflow(ovf1), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  // Reference state: index 0 models the wrapping instance, 1 the plain one.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] seen[$];
  bit         m_write [2];
  logic [8:0] m_data  [2];
  bit         m_ovf   [2];
  int         m_col   [2];
  bit         m_line  [2];
  bit         m_pend  [2];
  logic [8:0] init_seq [NUM_INIT] = '{9'h038, 9'h00c, 9'h001, 9'h006, 9'h080};
  logic [7:0] cmds [6] = '{8'h01, 8'h02, 8'hc5, 8'h8f, 8'hbf, 8'h14};

  function automatic int q_size(int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void q_push(int i, logic [8:0] v);
    if (i == 0) q0.push_back(v);
    else q1.push_back(v);
  endfunction

  function automatic logic [8:0] q_pop(int i);
    if (i == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic bit model_wait(int i);
    return (q_size(i) == int'(DEPTH)) || m_pend[i];
  endfunction

  function automatic void model_reset();
    q0.delete();
    q1.delete();
    for (int k = 0; k < int'(NUM_INIT); k++) begin
      q0.push_back(init_seq[k]);
      q1.push_back(init_seq[k]);
    end
    for (int i = 0; i < 2; i++) begin
      m_write[i] = 0; m_data[i] = '0; m_ovf[i] = 0;
      m_col[i] = 0; m_line[i] = 0; m_pend[i] = 0;
    end
  endfunction

  // One clock of the reference, using the inputs currently driven.
  function automatic void model_step(int i, bit aw);
    int n;
    bit pop, space, wrap_ins, acc;
    n        = q_size(i);
    pop      = (n > 0) && !(lcd_status || m_write[i]);
    space    = (n < int'(DEPTH)) || pop;
    wrap_ins = m_pend[i] && space;
    acc      = wr_en && !m_pend[i] && space;
    m_write[i] = pop;
    if (pop) m_data[i] = q_pop(i);
    if (wrap_ins) begin
      q_push(i, m_line[i] ? 9'h080 : 9'h0c0);
      m_col[i] = 0; m_line[i] = !m_line[i]; m_pend[i] = 0;
    end else if (acc) begin
      q_push(i, {wr_rs, wr_data});
      if (aw) begin
        if (wr_rs) begin
          m_col[i]++;
          if (m_col[i] == COLS) m_pend[i] = 1;
        end else if (wr_data == 8'h01 || wr_data == 8'h02) begin
          m_col[i] = 0; m_line[i] = 0;
        end else if (wr_data[7]) begin
          m_line[i] = wr_data[6];
          m_col[i]  = (int'(wr_data[5:0]) >= COLS) ? COLS - 1 : int'(wr_data[5:0]);
        end
      end
    end
    if (wr_en && !acc) m_ovf[i] = 1;
    else if (clr_ovf) m_ovf[i] = 0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("count_wrap", 32'(cnt0), q0.size());
    chk("count_nowrap", 32'(cnt1), q1.size());
    chk("wait_wrap", 32'(ww0), 32'(model_wait(0)));
    chk("wait_nowrap", 32'(ww1), 32'(model_wait(1)));
    chk("write_wrap", 32'(lw0), 32'(m_write[0]));
    chk("write_nowrap", 32'(lw1), 32'(m_write[1]));
    if (m_write[0]) chk("wrdata_wrap", 32'(ld0), 32'(m_data[0]));
    if (m_write[1]) chk("wrdata_nowrap", 32'(ld1), 32'(m_data[1]));
    chk("ovf_wrap", 32'(ovf0), 32'(m_ovf[0]));
    chk("ovf_nowrap", 32'(ovf1), 32'(m_ovf[1]));
    if (lw0 === 1'b1) seen.push_back(ld0);
  endtask

  task automatic cycle();
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(int n);
    wr_en = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic push(logic rs, logic [7:0] d);
    wr_en = 1'b1; wr_rs = rs; wr_data = d;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic push_wait(logic rs, logic [7:0] d);
    int guard = 0;
    wr_en = 1'b0;
    while (model_wait(0) && guard < 200) begin
      cycle();
      guard++;
    end
    chk("producer_wait_bound", 32'(guard < 200), 1);
    push(rs, d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_en = 1'b0; clr_ovf = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    check_all();
    chk("reset_wrdata", 32'(ld0), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    model_reset();
    @(negedge clk);
    check_all();
    chk("reset_wrdata", 32'(ld0), 0);
    rst_n = 1'b1;

    // Init sequence drains in order, one strobe every other cycle.
    seen.delete();
    idle(14);
    chk("init_strobes", seen.size(), NUM_INIT);
    for (int k = 0; k < int'(NUM_INIT) && k < seen.size(); k++) begin
      chk($sformatf("init_strobe%0d", k), 32'(seen[k]), 32'(init_seq[k]));
    end
    chk("init_drained", 32'(cnt0), 0);

    // Fill under a busy display: plain instance tops out and flags drops.
    lcd_status = 1'b1;
    for (int k = 0; k < 40; k++) push(1'b1, 8'($urandom));
    chk("full_count", 32'(cnt1), DEPTH);
    chk("full_wait", 32'(ww1), 1);
    chk("full_ovf", 32'(ovf1), 1);
    clr_ovf = 1'b1;
    cycle();
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(ovf1), 0);

    // Push into a full queue on the same cycle as a pop.
    lcd_status = 1'b0;
    push(1'b1, 8'h5a);
    chk("push_pop_count", 32'(cnt1), DEPTH);
    chk("push_pop_ovf", 32'(ovf1), 0);
    chk("push_pop_strobe", 32'(lw1), 1);
    lcd_status = 1'b1;
    idle(2);
    lcd_status = 1'b0;
    idle(70);

    // 16 chars wrap to line 1, 16 more wrap back to line 0.
    do_reset();
    for (int k = 0; k < COLS; k++) push(1'b1, 8'h41 + 8'(k));
    chk("wrap1_wait", 32'(ww0), 1);
    idle(1);
    chk("wrap1_released", 32'(ww0), 0);
    for (int k = 0; k < COLS; k++) push_wait(1'b1, 8'h61 + 8'(k));
    chk("wrap2_wait", 32'(ww0), 1);
    idle(80);

    // Cursor set to line 1 col 5: 11 chars fill the line and wrap back with 080.
    push(1'b0, 8'hc5);
    for (int k = 0; k < 10; k++) push(1'b1, 8'h30 + 8'(k));
    chk("setaddr_no_wrap", 32'(ww0), 0);
    push(1'b1, 8'h3a);
    chk("setaddr_wrap_wait", 32'(ww0), 1);
    idle(40);

    // Randomised traffic with a mostly well-behaved producer.
    for (int k = 0; k < 400; k++) begin
      lcd_status = ($urandom_range(0, 2) == 0);
      clr_ovf    = ($urandom_range(0, 15) == 0);
      wr_rs      = ($urandom_range(0, 3) != 0);
      wr_data    = wr_rs ? 8'($urandom) : cmds[$urandom_range(0, 5)];
      wr_en      = ($urandom_range(0, 2) != 0) &&
                   (!model_wait(0) || $urandom_range(0, 7) == 0);
      cycle();
    end
    wr_en = 1'b0; clr_ovf = 1'b0; lcd_status = 1'b0;
    idle(80);

    // Reset asserted in the middle of a strobe.
    do_reset();
    lcd_status = 1'b1;
    for (int k = 0; k < 5; k++) push(1'b1, 8'h20 + 8'(k));
    chk("preabort_count", 32'(cnt0), 10);
    lcd_status = 1'b0;
    guard = 0;
    while (!m_write[0] && guard < 10) begin
      cycle();
      guard++;
    end
    chk("strobe_seen_bound", 32'(guard < 10), 1);
    chk("strobe_live", 32'(lw0), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_write_wrap", 32'(lw0), 0);
    chk("abort_write_nowrap", 32'(lw1), 0);
    chk("abort_count", 32'(cnt0), NUM_INIT);
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    idle(14);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
